// File: rtl/ram_scan_pkg.sv
// Shared definitions for the RAM scan reader: FSM state encoding and default RAM geometry.
package ram_scan_pkg;

    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_DATA_W = 4;
    localparam int unsigned LAST_ADDR  = 2**DEF_ADDR_W - 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_HOLD   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/hold_timer.sv
// Enabled cycle counter with synchronous clear; o_expire marks the last enabled cycle of a period.
// Also usable as a plain rate divider (tie i_clr low, i_en high).
module hold_timer #(
    parameter int unsigned CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int unsigned      CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] L_TERM = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_term;

    assign w_term   = (r_cnt == L_TERM);
    assign o_expire = w_term & i_en;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_term ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ram_scan_reader.sv
// Read-side sweeper for the 32x4 RAM: fetches each word, shows it on the display path for a
// programmable hold, with pause and single-step. Optional checksum output: RAM_SCAN_CHECKSUM_EN.
module ram_scan_reader
    import ram_scan_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned RD_LATENCY  = 1,
    parameter int unsigned HOLD_CYCLES = 50000000
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              pause,
    input  logic              step,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              busy,
    output logic              done
`ifdef RAM_SCAN_CHECKSUM_EN
    ,
    output logic [ADDR_W+DATA_W-1:0] checksum
`endif
);

    localparam logic [ADDR_W-1:0] L_LAST = {ADDR_W{1'b1}};

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_lat;
    logic [ADDR_W-1:0] r_disp_addr;
    logic [DATA_W-1:0] r_disp_data;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;
    logic              w_tmr_clr;
    logic              w_tmr_en;
    logic              w_expire;

    // Timer restarts while the word is being fetched, so each hold starts from zero.
    assign w_tmr_clr = (r_state == S_WAIT);
    assign w_tmr_en  = (r_state == S_HOLD) & ~pause;

    hold_timer #(
        .CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .i_clk    (clock),
        .i_rst_n  (resetn),
        .i_clr    (w_tmr_clr),
        .i_en     (w_tmr_en),
        .o_expire (w_expire)
    );

`ifdef RAM_SCAN_CHECKSUM_EN
    logic [ADDR_W+DATA_W-1:0] r_sum;
    assign checksum = r_sum;
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_lat       <= 1'b0;
            r_disp_addr <= '0;
            r_disp_data <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef RAM_SCAN_CHECKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
`ifdef RAM_SCAN_CHECKSUM_EN
                        r_sum   <= '0;
`endif
                    end
                end
                S_ISSUE: begin
                    r_lat   <= 1'(RD_LATENCY - 1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Capture edge: q reflects mem_address RD_LATENCY+1 edges after it changed.
                    if (r_lat == 1'b0) begin
                        r_disp_data <= mem_q;
                        r_disp_addr <= r_addr;
                        r_valid     <= 1'b1;
                        r_state     <= S_HOLD;
`ifdef RAM_SCAN_CHECKSUM_EN
                        r_sum       <= r_sum + (ADDR_W+DATA_W)'(mem_q);
`endif
                    end else begin
                        r_lat <= r_lat - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_expire || step) begin
                        if (r_addr != L_LAST) begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= S_ISSUE;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_address = r_addr;
    assign mem_wren    = 1'b0;
    assign disp_addr   = r_disp_addr;
    assign disp_data   = r_disp_data;
    assign disp_valid  = r_valid;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_ram_scan_reader.sv
// Scoreboard bench for ram_scan_reader: two instances (read latency 1 and 2) share stimulus;
// expected words are queued at each start and a monitor checks order, data and timing.
`timescale 1ns/1ps
module tb_ram_scan_reader;

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 4;
    localparam int unsigned NWORD = 32;
    localparam int unsigned HOLD  = 4;
    localparam int unsigned LAT0  = 1;
    localparam int unsigned LAT1  = 2;

    logic          clock = 1'b0;
    logic          resetn;
    logic          start;
    logic          pause;
    logic          step;
    logic [AW-1:0] mem_address [2];
    logic          mem_wren    [2];
    logic [DW-1:0] mem_q       [2];
    logic [AW-1:0] disp_addr   [2];
    logic [DW-1:0] disp_data   [2];
    logic          disp_valid  [2];
    logic          busy        [2];
    logic          done        [2];
`ifdef RAM_SCAN_CHECKSUM_EN
    logic [AW+DW-1:0] checksum [2];
    int               m_sum    [2];
`endif

    logic [DW-1:0] mem [NWORD];
    logic [DW-1:0] q0_s1, q1_s1, q1_s2;

    logic [AW+DW-1:0] exp_q0[$];
    logic [AW+DW-1:0] exp_q1[$];

    int total = 0;
    int bad   = 0;
    int timeouts = 0;
    bit stim_done = 1'b0;

    // Reference model state per instance
    bit          m_act  [2];
    bit          m_hold [2];
    bit          m_fin  [2];
    int          m_cnt  [2];
    int          m_due  [2];
    int          m_addr [2];
    bit          pv     [2];
    logic [AW-1:0] paddr [2];

    always #5 clock = ~clock;

    ram_scan_reader #(
        .ADDR_W (AW), .DATA_W (DW), .RD_LATENCY (LAT0), .HOLD_CYCLES (HOLD)
    ) u_dut0 (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .pause       (pause),
        .step        (step),
        .mem_address (mem_address[0]),
        .mem_wren    (mem_wren[0]),
        .mem_q       (mem_q[0]),
        .disp_addr   (disp_addr[0]),
        .disp_data   (disp_data[0]),
        .disp_valid  (disp_valid[0]),
        .busy        (busy[0]),
        .done        (done[0])
`ifdef RAM_SCAN_CHECKSUM_EN
        ,
        .checksum    (checksum[0])
`endif
    );

    ram_scan_reader #(
        .ADDR_W (AW), .DATA_W (DW), .RD_LATENCY (LAT1), .HOLD_CYCLES (HOLD)
    ) u_dut1 (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .pause       (pause),
        .step        (step),
        .mem_address (mem_address[1]),
        .mem_wren    (mem_wren[1]),
        .mem_q       (mem_q[1]),
        .disp_addr   (disp_addr[1]),
        .disp_data   (disp_data[1]),
        .disp_valid  (disp_valid[1]),
        .busy        (busy[1]),
        .done        (done[1])
`ifdef RAM_SCAN_CHECKSUM_EN
        ,
        .checksum    (checksum[1])
`endif
    );

    // Synchronous RAM models with 1 and 2 clocks of read latency
    always @(posedge clock) begin
        q0_s1 <= mem[mem_address[0]];
        q1_s1 <= mem[mem_address[1]];
        q1_s2 <= q1_s1;
    end
    assign mem_q[0] = q0_s1;
    assign mem_q[1] = q1_s2;

    task automatic check(input string name, input int i, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s dut%0d got=%0h want=%0h t=%0t", name, i, got, want, $time);
        end
    endtask

    task automatic push_sweep();
        logic [AW-1:0] a;
        for (int k = 0; k < int'(NWORD); k++) begin
            a = AW'(k);
            exp_q0.push_back({a, mem[k]});
            exp_q1.push_back({a, mem[k]});
        end
    endtask

    task automatic model_step(input int i, input int n);
        int   lat;
        bit   cap, exp_cap, ex, last;
        logic [AW+DW-1:0] e;
        lat  = (i == 0) ? int'(LAT0) : int'(LAT1);
        if (!resetn) begin
            check("reset_outputs", i,
                  {mem_address[i], disp_addr[i], disp_data[i], disp_valid[i], busy[i], done[i],
                   mem_wren[i]}, 32'd0);
`ifdef RAM_SCAN_CHECKSUM_EN
            check("reset_checksum", i, 32'(checksum[i]), 32'd0);
            m_sum[i] = 0;
`endif
            m_act[i] = 0; m_hold[i] = 0; m_fin[i] = 0; m_cnt[i] = 0; m_addr[i] = 0;
            pv[i] = 0; paddr[i] = '0;
            if (i == 0) exp_q0.delete(); else exp_q1.delete();
            return;
        end
        cap     = disp_valid[i] && (!pv[i] || disp_addr[i] != paddr[i]);
        exp_cap = m_act[i] && !m_hold[i] && (n == m_due[i]);
        ex      = 0;
        last    = 0;
        if (cap || exp_cap) check("capture_timing", i, 32'(cap), 32'(exp_cap));
        if (exp_cap && cap) begin
            if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
                total++;
                bad++;
                $display("FAIL sb_underflow dut%0d got=%0h want=<none>", i,
                         {disp_addr[i], disp_data[i]});
            end else begin
                e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                check("captured_word", i, 32'({disp_addr[i], disp_data[i]}), 32'(e));
`ifdef RAM_SCAN_CHECKSUM_EN
                m_sum[i] += int'(e[DW-1:0]);
`endif
            end
        end
        if (m_fin[i]) begin
            m_fin[i] = 0;
        end else if (!m_act[i]) begin
            if (start) begin
                m_act[i] = 1; m_hold[i] = 0; m_addr[i] = 0; m_due[i] = n + 1 + lat;
`ifdef RAM_SCAN_CHECKSUM_EN
                m_sum[i] = 0;
                check("checksum_cleared", i, 32'(checksum[i]), 32'd0);
`endif
            end
        end else if (!m_hold[i]) begin
            if (exp_cap) begin
                m_hold[i] = 1;
                m_cnt[i]  = 0;
            end
        end else begin
            // A hold lasts HOLD unpaused clocks, or ends on any step.
            if (!pause) m_cnt[i]++;
            ex = step || (!pause && m_cnt[i] == int'(HOLD));
            if (ex) begin
                if (m_addr[i] == int'(NWORD) - 1) begin
                    last = 1; m_act[i] = 0; m_fin[i] = 1;
                end else begin
                    m_addr[i]++; m_hold[i] = 0; m_due[i] = n + 1 + lat;
                end
            end
        end
        check("busy_done_wren", i, {busy[i], done[i], mem_wren[i]}, {m_act[i], last, 1'b0});
`ifdef RAM_SCAN_CHECKSUM_EN
        if (last) check("checksum_final", i, 32'(checksum[i]), 32'(m_sum[i]));
`endif
        pv[i]    = disp_valid[i];
        paddr[i] = disp_addr[i];
    endtask

    // Monitor: samples 1 ns after each rising edge
    initial begin
        int n;
        n = 0;
        forever begin
            @(posedge clock);
            #1;
            n++;
            for (int i = 0; i < 2; i++) model_step(i, n);
            if (stim_done) begin
                check("sb_empty", 0, 32'(exp_q0.size()), 32'd0);
                check("sb_empty", 1, 32'(exp_q1.size()), 32'd0);
                check("wait_timeouts", 0, 32'(timeouts), 32'd0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic wait_idle(input int limit);
        for (int k = 0; k < limit; k++) begin
            @(posedge clock);
            #1;
            if (!busy[0] && !busy[1] && !done[0] && !done[1]) return;
        end
        timeouts++;
        $display("FAIL wait_idle got=busy want=idle");
    endtask

    task automatic wait_addr0(input int target, input int limit);
        for (int k = 0; k < limit; k++) begin
            @(posedge clock);
            #1;
            if (disp_valid[0] && int'(disp_addr[0]) == target) return;
        end
        timeouts++;
        $display("FAIL wait_addr got=%0d want=%0d", disp_addr[0], target);
    endtask

    task automatic do_start();
        @(negedge clock);
        start = 1'b1;
        push_sweep();
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic fill_xor();
        logic [AW-1:0] a;
        for (int k = 0; k < int'(NWORD); k++) begin
            a = AW'(k);
            mem[k] = a[3:0] ^ 4'hA;
        end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; pause = 1'b0; step = 1'b0;
        fill_xor();
        repeat (2) @(negedge clock);
        resetn = 1'b1;

        // Full sweep with an ignored start pulse mid-sweep
        wait_idle(50);
        do_start();
        repeat (37) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_idle(1000);

        // Random data with random pause, step and ignored starts
        for (int k = 0; k < int'(NWORD); k++) mem[k] = DW'($urandom_range(0, 15));
        do_start();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            if (!busy[0] && !busy[1]) break;
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            step  = ($urandom_range(0, 15) == 0);
            start = busy[0] && busy[1] && ($urandom_range(0, 31) == 0);
        end
        @(negedge clock);
        pause = 1'b0; step = 1'b0; start = 1'b0;
        wait_idle(1000);

        // Long pause on address 3, then a step while paused
        fill_xor();
        do_start();
        wait_addr0(3, 200);
        @(negedge clock);
        pause = 1'b1;
        repeat (500) @(negedge clock);
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        repeat (5) @(negedge clock);
        pause = 1'b0;
        wait_idle(1000);

        // Step coinciding with timer expiry on address 5
        do_start();
        wait_addr0(5, 200);
        repeat (HOLD) @(negedge clock);
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        wait_idle(1000);

        // Reset in the middle of a sweep
        do_start();
        wait_addr0(17, 400);
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        wait_idle(50);

        // All-ones data twice: sum of 32 words is 480 each time
        for (int k = 0; k < int'(NWORD); k++) mem[k] = 4'hF;
        do_start();
        wait_idle(1000);
        do_start();
        wait_idle(1000);

        repeat (3) @(negedge clock);
        stim_done = 1'b1;
    end

endmodule
